// File: rtl/payment_to_time.sv
// Payment to parking time: coin credit accumulator plus a bit-serial
// restoring divider that turns credit into purchased seconds.
module payment_to_time #(
    parameter int MAX_CREDIT = 9999,
    parameter int DIV_BITS   = 21,
    parameter int MAX_SEC    = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sw,
    input  logic        coin_valid,
    input  logic [7:0]  coin_cents,
    output logic        coin_ready,
    input  logic        start,
    input  logic        clear,
    output logic        busy,
    output logic        done,
    output logic [11:0] sec_count,
    output logic [13:0] credit_cents,
    output logic        err,
    output logic        sat
);
    typedef enum logic [1:0] {IDLE, DIV, SCALE} state_t;
    localparam int CW = $clog2(DIV_BITS);

    state_t              state, state_nx;
    logic [CW-1:0]       cnt;
    logic [DIV_BITS-1:0] dvd;
    logic [7:0]          dsr;
    logic [7:0]          rem;
    logic                err_pend;
    logic                load, step, finish;

    logic [8:0]  rem_sh, rem_diff;
    logic        ge;
    logic [14:0] credit_sum;
    logic [19:0] secs;

    function automatic logic [7:0] rate_of(input logic [7:0] s);
        logic [4:0] hr;
        hr = s[4:0];
        if (s[7:5] == 3'd0) begin
            if (hr < 5'd8)       return 8'd145;
            else if (hr < 5'd13) return 8'd167;
            else if (hr < 5'd18) return 8'd189;
            else                 return 8'd145;
        end else begin
            if (hr < 5'd8)       return 8'd134;
            else if (hr < 5'd13) return 8'd156;
            else if (hr < 5'd18) return 8'd178;
            else                 return 8'd156;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !clear) begin
                    state_nx = DIV;
                    load     = 1'b1;
                end
            end
            DIV: begin
                if (clear) begin
                    state_nx = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) state_nx = SCALE;
                end
            end
            SCALE: begin
                state_nx = IDLE;
                finish   = !clear;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign coin_ready = (state == IDLE) && !start && !clear;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_sh     = {rem, dvd[DIV_BITS-1]};
    assign rem_diff   = rem_sh - {1'b0, dsr};
    assign ge         = (rem_sh >= {1'b0, dsr});
    assign credit_sum = {1'b0, credit_cents} + 15'(coin_cents);
    assign secs       = 20'(dvd[13:0]) * 20'd60;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_cents <= '0;
            dvd          <= '0;
            dsr          <= '0;
            rem          <= '0;
            cnt          <= '0;
            err_pend     <= 1'b0;
            sec_count    <= '0;
            err          <= 1'b0;
            sat          <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= finish;
            if (clear) begin
                credit_cents <= '0;
            end else if (coin_ready && coin_valid) begin
                if (credit_sum > 15'(MAX_CREDIT))
                    credit_cents <= 14'(MAX_CREDIT);
                else
                    credit_cents <= credit_sum[13:0];
            end
            if (load) begin
                dvd      <= DIV_BITS'(credit_cents) * DIV_BITS'(100);
                dsr      <= rate_of(sw);
                rem      <= '0;
                cnt      <= CW'(DIV_BITS - 1);
                err_pend <= (sw[4:0] >= 5'd24);
            end
            // Quotient bits shift into the dividend register as it empties.
            if (step) begin
                rem <= ge ? rem_diff[7:0] : rem_sh[7:0];
                dvd <= {dvd[DIV_BITS-2:0], ge};
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                err <= err_pend;
                if (err_pend) begin
                    sec_count <= '0;
                    sat       <= 1'b0;
                end else if (secs > 20'(MAX_SEC)) begin
                    sec_count <= 12'(MAX_SEC);
                    sat       <= 1'b1;
                end else begin
                    sec_count <= secs[11:0];
                    sat       <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_payment_to_time.sv
// Directed bench for payment_to_time with a cycle-level reference model
// checked after every clock edge.
module tb_payment_to_time;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sw;
    logic        coin_valid;
    logic [7:0]  coin_cents;
    logic        coin_ready;
    logic        start;
    logic        clear;
    logic        busy;
    logic        done;
    logic [11:0] sec_count;
    logic [13:0] credit_cents;
    logic        err;
    logic        sat;

    int n_cmp = 0;
    int n_bad = 0;

    int m_credit = 0;
    int m_left   = 0;
    int m_done   = 0;
    int m_sec    = 0;
    int m_err    = 0;
    int m_sat    = 0;
    int p_sec, p_err, p_sat;

    payment_to_time dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .coin_valid(coin_valid), .coin_cents(coin_cents),
        .coin_ready(coin_ready), .start(start), .clear(clear),
        .busy(busy), .done(done), .sec_count(sec_count),
        .credit_cents(credit_cents), .err(err), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int rate_for(input int loc, input int hr);
        if (loc == 0) begin
            if (hr <= 7)  return 145;
            if (hr <= 12) return 167;
            if (hr <= 17) return 189;
            return 145;
        end
        if (hr <= 7)  return 134;
        if (hr <= 12) return 156;
        if (hr <= 17) return 178;
        return 156;
    endfunction

    task automatic model_edge();
        int hr, minutes, s;
        if (!rst_n) begin
            m_credit = 0; m_left = 0; m_done = 0;
            m_sec = 0; m_err = 0; m_sat = 0;
            return;
        end
        m_done = 0;
        if (m_left > 0) begin
            if (clear) begin
                m_left = 0;
                m_credit = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_sec = p_sec; m_err = p_err; m_sat = p_sat;
                end
            end
        end else if (clear) begin
            m_credit = 0;
        end else if (start) begin
            hr = int'(sw[4:0]);
            if (hr >= 24) begin
                p_err = 1; p_sec = 0; p_sat = 0;
            end else begin
                minutes = (m_credit * 100) / rate_for(int'(sw[7:5]), hr);
                s = minutes * 60;
                p_err = 0;
                p_sat = (s > 4095) ? 1 : 0;
                p_sec = (s > 4095) ? 4095 : s;
            end
            m_left = 22;
        end else if (coin_valid) begin
            m_credit = m_credit + int'(coin_cents);
            if (m_credit > 9999) m_credit = 9999;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
        chk("done", int'(done), m_done);
        chk("credit_cents", int'(credit_cents), m_credit);
        chk("coin_ready", int'(coin_ready),
            (m_left == 0 && !start && !clear) ? 1 : 0);
        chk("sec_count", int'(sec_count), m_sec);
        chk("err", int'(err), m_err);
        chk("sat", int'(sat), m_sat);
    endtask

    task automatic coin(input int c);
        coin_valid = 1'b1;
        coin_cents = 8'(c);
        step();
        coin_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic convert(output int lat);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; sw = '0; coin_valid = 1'b0; coin_cents = '0;
        start = 1'b0; clear = 1'b0;
        step(); step();
        chk("reset sec_count", int'(sec_count), 0);
        chk("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        step();

        // loc0 hr3: 2900/145 = 20 min
        sw = {3'd0, 5'd3};
        coin(25); coin(4);
        chk("t1 credit", int'(credit_cents), 29);
        convert(lat);
        chk("t1 latency", lat, 23);
        chk("t1 sec_count", int'(sec_count), 1200);
        chk("t1 sat", int'(sat), 0);
        chk("t1 err", int'(err), 0);
        step();

        // loc1 hr14: 5000/178 = 28 min
        do_clear();
        sw = {3'd1, 5'd14};
        coin(25); coin(25);
        convert(lat);
        chk("t2 sec_count", int'(sec_count), 1680);

        do_clear();
        convert(lat);
        chk("zero credit sec_count", int'(sec_count), 0);

        // loc1 hr2: 20000/134 = 149 min -> clipped
        sw = {3'd1, 5'd2};
        repeat (4) coin(50);
        convert(lat);
        chk("t3 sec_count", int'(sec_count), 4095);
        chk("t3 sat", int'(sat), 1);

        // hour 25 with a coin held through the conversion
        do_clear();
        sw = {3'd0, 5'd25};
        coin(50); coin(50);
        start = 1'b1;
        coin_valid = 1'b1;
        coin_cents = 8'd50;
        step();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        coin_valid = 1'b0;
        chk("t4 latency", lat, 23);
        chk("t4 err", int'(err), 1);
        chk("t4 sec_count", int'(sec_count), 0);
        chk("t4 credit", int'(credit_cents), 100);
        step();

        // saturating credit, then coin+start together
        do_clear();
        sw = {3'd0, 5'd10};
        repeat (40) coin(250);
        chk("t5 credit", int'(credit_cents), 9999);
        coin_valid = 1'b1;
        coin_cents = 8'd100;
        convert(lat);
        coin_valid = 1'b0;
        chk("t5 credit after", int'(credit_cents), 9999);
        chk("t5 sec_count", int'(sec_count), 4095);
        step();

        // abort mid-divide
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t6 busy", int'(busy), 0);
        chk("t6 credit", int'(credit_cents), 0);
        chk("t6 sec_count kept", int'(sec_count), 4095);
        repeat (25) step();

        // reset mid-divide
        coin(200);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk("t6 rst sec_count", int'(sec_count), 0);
        chk("t6 rst credit", int'(credit_cents), 0);
        chk("t6 rst busy", int'(busy), 0);
        chk("t6 rst sat", int'(sat), 0);
        rst_n = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
